// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, imem read handshake, one-entry skid buffer and IF/ID register.
// Optional performance counters are built when FETCH_PERF_EN is defined.
module fetch_unit #(
    parameter int                WORD_W    = 32,
    parameter logic [WORD_W-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [WORD_W-1:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic              CLK,
    input  logic              RST,
    output logic              imem_ren,
    output logic [WORD_W-1:0] imem_addr,
    input  logic [WORD_W-1:0] imem_rdata,
    input  logic              imem_hit,
    input  logic              stall,
    input  logic              redirect,
    input  logic [WORD_W-1:0] redirect_pc,
    input  logic              halt,
    output logic [WORD_W-1:0] instr,
    output logic              instr_valid,
    output logic [WORD_W-1:0] instr_pc,
    output logic [WORD_W-1:0] instr_pc4,
    output logic              halted
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_stall_cyc
`endif
);

    localparam logic [WORD_W-1:0] PC_STEP = WORD_W'(4);

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_HOLD   = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t            state_reg;
    logic [WORD_W-1:0] pc_reg;
    logic [WORD_W-1:0] instr_reg;
    logic              valid_reg;
    logic [WORD_W-1:0] ipc_reg;
    logic [WORD_W-1:0] ipc4_reg;
    logic [WORD_W-1:0] skid_instr_reg;
    logic [WORD_W-1:0] skid_pc_reg;
    logic              halted_reg;

    logic [WORD_W-1:0] redirect_target;
    logic              take_halt;
    logic              redirect_lsb_unused;

    assign redirect_target     = {redirect_pc[WORD_W-1:2], 2'b00};
    assign redirect_lsb_unused = ^redirect_pc[1:0];
    assign take_halt           = halt && valid_reg;

    // Request is a function of registered state only; the RST term keeps it low while reset is held.
    assign imem_ren    = (state_reg == ST_FETCH) && !RST;
    assign imem_addr   = pc_reg;
    assign instr       = instr_reg;
    assign instr_valid = valid_reg;
    assign instr_pc    = ipc_reg;
    assign instr_pc4   = ipc4_reg;
    assign halted      = halted_reg;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg      <= ST_FETCH;
            pc_reg         <= RESET_PC;
            instr_reg      <= NOP_INSTR;
            valid_reg      <= 1'b0;
            ipc_reg        <= RESET_PC;
            ipc4_reg       <= RESET_PC + PC_STEP;
            skid_instr_reg <= NOP_INSTR;
            skid_pc_reg    <= RESET_PC;
            halted_reg     <= 1'b0;
        end else begin
            case (state_reg)
                ST_HALTED: ;
                default: begin
                    if (redirect) begin
                        // Leaving HOLD here drops the skid entry and any hit this cycle.
                        pc_reg    <= redirect_target;
                        instr_reg <= NOP_INSTR;
                        valid_reg <= 1'b0;
                        state_reg <= ST_FETCH;
                    end else if (take_halt) begin
                        instr_reg  <= NOP_INSTR;
                        valid_reg  <= 1'b0;
                        state_reg  <= ST_HALTED;
                        halted_reg <= 1'b1;
                    end else if (state_reg == ST_HOLD) begin
                        if (!stall) begin
                            instr_reg <= skid_instr_reg;
                            ipc_reg   <= skid_pc_reg;
                            ipc4_reg  <= skid_pc_reg + PC_STEP;
                            valid_reg <= 1'b1;
                            state_reg <= ST_FETCH;
                        end
                    end else if (imem_hit) begin
                        pc_reg <= pc_reg + PC_STEP;
                        if (stall) begin
                            skid_instr_reg <= imem_rdata;
                            skid_pc_reg    <= pc_reg;
                            state_reg      <= ST_HOLD;
                        end else begin
                            instr_reg <= imem_rdata;
                            ipc_reg   <= pc_reg;
                            ipc4_reg  <= pc_reg + PC_STEP;
                            valid_reg <= 1'b1;
                        end
                    end else if (!stall) begin
                        // Decode consumed the previous word and nothing new arrived.
                        instr_reg <= NOP_INSTR;
                        valid_reg <= 1'b0;
                    end
                end
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_reg;
    logic [31:0] perf_stall_cyc_reg;
    logic        ifid_fill;

    assign ifid_fill = !redirect && !take_halt && !stall &&
                       ((state_reg == ST_HOLD) || ((state_reg == ST_FETCH) && imem_hit));

    always_ff @(posedge CLK) begin
        if (RST) begin
            perf_fetched_reg   <= '0;
            perf_stall_cyc_reg <= '0;
        end else if (state_reg != ST_HALTED) begin
            if (ifid_fill) begin
                perf_fetched_reg <= perf_fetched_reg + 32'd1;
            end
            if ((state_reg == ST_HOLD) || !imem_hit) begin
                perf_stall_cyc_reg <= perf_stall_cyc_reg + 32'd1;
            end
        end
    end

    assign perf_fetched   = perf_fetched_reg;
    assign perf_stall_cyc = perf_stall_cyc_reg;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed vector table for the multi-cycle corner cases,
// then randomized traffic checked against a queue-based reference model.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        CLK = 1'b0;
    logic        RST;
    logic        imem_ren;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_hit;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halt;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] instr_pc;
    logic [31:0] instr_pc4;
    logic        halted;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall_cyc;
`endif

    fetch_unit dut (
        .CLK(CLK), .RST(RST),
        .imem_ren(imem_ren), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_hit(imem_hit),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
        .instr(instr), .instr_valid(instr_valid), .instr_pc(instr_pc),
        .instr_pc4(instr_pc4), .halted(halted)
`ifdef FETCH_PERF_EN
        , .perf_fetched(perf_fetched), .perf_stall_cyc(perf_stall_cyc)
`endif
    );

    always #5 CLK = ~CLK;

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct {
        logic        rst, hit, stl, rdr;
        logic [31:0] rpc;
        logic        hlt;
        logic [31:0] e_addr;
        logic        e_ren, e_valid;
        logic [31:0] e_pc;
        logic        e_halted;
    } vec_t;

    vec_t vecs[23];

    typedef struct {
        logic [31:0] w;
        logic [31:0] pc;
    } skid_t;

    // Reference model state
    logic [31:0] m_pc, m_instr, m_ipc;
    logic        m_valid, m_halted;
    skid_t       m_skid[$];
    logic [31:0] m_fetched, m_stallc;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        if (a == 32'h0) return 32'h00A0_0093;
        if (a == 32'h4) return 32'h0010_0113;
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
    endfunction

    function automatic vec_t mk(input logic r, h, s, d, input logic [31:0] rp, input logic hl,
                                input logic [31:0] ea, input logic er, ev,
                                input logic [31:0] ep, input logic eh);
        vec_t v;
        v.rst = r; v.hit = h; v.stl = s; v.rdr = d; v.rpc = rp; v.hlt = hl;
        v.e_addr = ea; v.e_ren = er; v.e_valid = ev; v.e_pc = ep; v.e_halted = eh;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, h, s, d, input logic [31:0] rp, input logic hl);
        RST = r; imem_hit = h; stall = s; redirect = d; redirect_pc = rp; halt = hl;
        imem_rdata = h ? word_at(imem_addr) : 32'hDEAD_BEEF;
        @(posedge CLK);
        @(negedge CLK);
    endtask

    // Advance the model by one cycle given this cycle's inputs.
    task automatic model_step(input logic r, h, s, d, input logic [31:0] rp, input logic hl);
        skid_t e;
        if (r) begin
            m_pc = 32'h0; m_instr = NOP; m_valid = 1'b0; m_ipc = 32'h0;
            m_halted = 1'b0; m_skid.delete(); m_fetched = 0; m_stallc = 0;
            return;
        end
        if (m_halted) return;
        if (m_skid.size() != 0 || !h) m_stallc++;
        if (d) begin
            m_pc = rp & 32'hFFFF_FFFC; m_instr = NOP; m_valid = 1'b0; m_skid.delete();
        end else if (hl && m_valid) begin
            m_halted = 1'b1; m_instr = NOP; m_valid = 1'b0;
        end else if (m_skid.size() != 0) begin
            if (!s) begin
                e = m_skid.pop_front();
                m_instr = e.w; m_ipc = e.pc; m_valid = 1'b1; m_fetched++;
            end
        end else if (h) begin
            if (s) begin
                e.w = word_at(m_pc); e.pc = m_pc;
                m_skid.push_back(e);
            end else begin
                m_instr = word_at(m_pc); m_ipc = m_pc; m_valid = 1'b1; m_fetched++;
            end
            m_pc = m_pc + 32'd4;
        end else if (!s) begin
            m_instr = NOP; m_valid = 1'b0;
        end
    endtask

    logic        r_rst, r_hit, r_stl, r_rdr, r_hlt;
    logic [31:0] r_rpc;

    initial begin
        RST = 1'b1; imem_hit = 1'b0; stall = 1'b0; redirect = 1'b0;
        redirect_pc = 32'h0; halt = 1'b0; imem_rdata = 32'h0;

        //            rst hit stl rdr rpc           hlt  addr          ren vld pc            hlt
        vecs[0]  = mk(1, 0, 0, 0, 32'h0,          0, 32'h0,          0, 0, 32'h0,          0);
        vecs[1]  = mk(0, 1, 0, 0, 32'h0,          0, 32'h4,          1, 1, 32'h0,          0);
        vecs[2]  = mk(0, 1, 0, 0, 32'h0,          0, 32'h8,          1, 1, 32'h4,          0);
        vecs[3]  = mk(0, 0, 0, 0, 32'h0,          0, 32'h8,          1, 0, 32'h4,          0);
        vecs[4]  = mk(0, 0, 0, 0, 32'h0,          0, 32'h8,          1, 0, 32'h4,          0);
        vecs[5]  = mk(0, 0, 0, 0, 32'h0,          0, 32'h8,          1, 0, 32'h4,          0);
        vecs[6]  = mk(0, 1, 0, 0, 32'h0,          0, 32'hC,          1, 1, 32'h8,          0);
        vecs[7]  = mk(0, 1, 0, 0, 32'h0,          0, 32'h10,         1, 1, 32'hC,          0);
        vecs[8]  = mk(0, 1, 1, 0, 32'h0,          0, 32'h14,         0, 1, 32'hC,          0);
        vecs[9]  = mk(0, 0, 1, 0, 32'h0,          0, 32'h14,         0, 1, 32'hC,          0);
        vecs[10] = mk(0, 0, 0, 0, 32'h0,          0, 32'h14,         1, 1, 32'h10,         0);
        vecs[11] = mk(0, 1, 0, 0, 32'h0,          0, 32'h18,         1, 1, 32'h14,         0);
        vecs[12] = mk(0, 1, 1, 0, 32'h0,          0, 32'h1C,         0, 1, 32'h14,         0);
        vecs[13] = mk(0, 0, 1, 1, 32'h203,        0, 32'h200,        1, 0, 32'h14,         0);
        vecs[14] = mk(0, 1, 0, 0, 32'h0,          0, 32'h204,        1, 1, 32'h200,        0);
        vecs[15] = mk(0, 1, 0, 1, 32'h40,         0, 32'h40,         1, 0, 32'h200,        0);
        vecs[16] = mk(0, 1, 0, 0, 32'h0,          0, 32'h44,         1, 1, 32'h40,         0);
        vecs[17] = mk(0, 1, 0, 0, 32'h0,          1, 32'h44,         0, 0, 32'h40,         1);
        vecs[18] = mk(0, 1, 0, 1, 32'h300,        0, 32'h44,         0, 0, 32'h40,         1);
        vecs[19] = mk(1, 0, 0, 0, 32'h0,          0, 32'h0,          0, 0, 32'h0,          0);
        vecs[20] = mk(0, 1, 0, 0, 32'h0,          0, 32'h4,          1, 1, 32'h0,          0);
        vecs[21] = mk(0, 0, 0, 1, 32'hFFFF_FFFC,  0, 32'hFFFF_FFFC,  1, 0, 32'h0,          0);
        vecs[22] = mk(0, 1, 0, 0, 32'h0,          0, 32'h0,          1, 1, 32'hFFFF_FFFC,  0);

        @(negedge CLK);
        for (int i = 0; i < 23; i++) begin
            drive(vecs[i].rst, vecs[i].hit, vecs[i].stl, vecs[i].rdr, vecs[i].rpc, vecs[i].hlt);
            $display("vec %0d: addr=%h ren=%b valid=%b pc=%h instr=%h halted=%b",
                     i, imem_addr, imem_ren, instr_valid, instr_pc, instr, halted);
            check($sformatf("v%0d_addr", i), imem_addr, vecs[i].e_addr);
            check($sformatf("v%0d_ren", i), 32'(imem_ren), 32'(vecs[i].e_ren));
            check($sformatf("v%0d_valid", i), 32'(instr_valid), 32'(vecs[i].e_valid));
            check($sformatf("v%0d_pc", i), instr_pc, vecs[i].e_pc);
            check($sformatf("v%0d_pc4", i), instr_pc4, vecs[i].e_pc + 32'd4);
            check($sformatf("v%0d_instr", i), instr,
                  vecs[i].e_valid ? word_at(vecs[i].e_pc) : NOP);
            check($sformatf("v%0d_halted", i), 32'(halted), 32'(vecs[i].e_halted));
        end

`ifdef FETCH_PERF_EN
        drive(1, 0, 0, 0, 32'h0, 0);
        for (int i = 0; i < 5; i++) drive(0, 1, 0, 0, 32'h0, 0);
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 32'h0, 0);
        $display("perf: fetched=%0d stall_cyc=%0d", perf_fetched, perf_stall_cyc);
        check("perf_fetched", perf_fetched, 32'd5);
        check("perf_stall_cyc", perf_stall_cyc, 32'd3);
`endif

        for (int c = 0; c < 2000; c++) begin
            r_rst = (c == 0) || ($urandom_range(0, 63) == 0);
            r_hit = ($urandom_range(0, 9) < 6);
            r_stl = ($urandom_range(0, 3) == 0);
            r_rdr = ($urandom_range(0, 11) == 0);
            r_rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                : $urandom();
            r_hlt = ($urandom_range(0, 99) == 0);
            model_step(r_rst, r_hit, r_stl, r_rdr, r_rpc, r_hlt);
            drive(r_rst, r_hit, r_stl, r_rdr, r_rpc, r_hlt);
            $display("cyc %0d: rst=%b hit=%b stl=%b rdr=%b hlt=%b addr=%h vld=%b pc=%h",
                     c, r_rst, r_hit, r_stl, r_rdr, r_hlt, imem_addr, instr_valid, instr_pc);
            check("rnd_addr", imem_addr, m_pc);
            check("rnd_ren", 32'(imem_ren), 32'(!r_rst && !m_halted && m_skid.size() == 0));
            check("rnd_valid", 32'(instr_valid), 32'(m_valid));
            check("rnd_instr", instr, m_instr);
            check("rnd_pc", instr_pc, m_ipc);
            check("rnd_pc4", instr_pc4, m_ipc + 32'd4);
            check("rnd_halted", 32'(halted), 32'(m_halted));
`ifdef FETCH_PERF_EN
            check("rnd_perf_fetched", perf_fetched, m_fetched);
            check("rnd_perf_stall", perf_stall_cyc, m_stallc);
`endif
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage that feeds the decode unit. Holds the program counter, drives the instruction memory read handshake, and registers each fetched word with its PC into the IF/ID register that drives decode's `instr` input. Takes redirects (taken branch, jump, jal) from execute, stall and flush from the hazard unit, and `halt` back from decode.

## Interface

- `RESET_PC`, default 32'h0000_0000: PC loaded on reset.
- `NOP_INSTR`, default 32'h0000_0013: bubble word placed in IF/ID (`addi x0,x0,0`).
- `CLK`, in, 1: the single clock; all state updates on rising edge.
- `RST`, in, 1: reset, synchronous, active-high.
- `imem_ren`, out, 1: instruction read request.
- `imem_addr`, out, WORD_W: read address, always equal to `pc`.
- `imem_rdata`, in, WORD_W: read data, valid when `imem_hit`.
- `imem_hit`, in, 1: read completes this cycle.
- `stall`, in, 1: hold IF/ID and PC (decode cannot accept).
- `redirect`, in, 1: control transfer resolved this cycle.
- `redirect_pc`, in, WORD_W: target; bits [1:0] ignored and forced to 0.
- `halt`, in, 1: decode reports the instruction in IF/ID is a halt.
- `instr`, out, WORD_W: IF/ID instruction to decode.
- `instr_valid`, out, 1: `instr` is a real fetched instruction.
- `instr_pc`, out, WORD_W: PC of `instr`.
- `instr_pc4`, out, WORD_W: `instr_pc + 4`, used by jal link.
- `halted`, out, 1: fetch has stopped.

## Operation

- State machine: FETCH, HOLD, HALTED. Reset enters FETCH.
- FETCH: `imem_ren`=1, address=`pc`.
  - `imem_hit` and not `stall`: IF/ID <= {`imem_rdata`, `pc`, valid=1}, `pc` <= `pc`+4, stay in FETCH.
  - `imem_hit` and `stall`: fetched word goes into a one-entry skid buffer, `pc` <= `pc`+4, go to HOLD. IF/ID is unchanged.
  - No hit: stay in FETCH and hold `pc`. The request stays asserted until the hit.
- HOLD: `imem_ren`=0. When `stall` drops, IF/ID <= skid entry and go to FETCH.
- `redirect` in FETCH or HOLD, top priority after RST:
  - `pc` <= `redirect_pc`.
  - IF/ID <= bubble (`NOP_INSTR`, valid=0).
  - Skid entry is discarded, any hit that cycle is discarded, go to FETCH.
  - Overrides `stall`.
- `halt` and `instr_valid` and not `redirect`: go to HALTED.
  - IF/ID <= bubble, `imem_ren`=0, `halted`=1.
  - Left only through RST; `redirect` is ignored in HALTED.
- Priority: RST > redirect > halt > stall > hit.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 wraps to 0 with no error.

## Timing

- Reset values:
  - `pc`=`RESET_PC`, state FETCH.
  - `instr`=`NOP_INSTR`, `instr_valid`=0, `instr_pc`=`RESET_PC`, `instr_pc4`=`RESET_PC`+4.
  - `halted`=0.
  - `imem_ren`=0 during the reset cycle, 1 in the first cycle after it.
- Latency: a hit in cycle N is on `instr` in cycle N+1. With zero-wait memory and no stall, throughput is one instruction per cycle.
- Redirect: asserted in cycle N, `imem_addr`=`redirect_pc` in N+1, bubble on `instr` in N+1.
- `imem_addr` and `imem_ren` are combinational from registered state only, with no path from `imem_hit`.
- RST during an outstanding miss or in HOLD: in-flight data is discarded and fetch restarts at `RESET_PC`.

## Configuration

- `FETCH_PERF_EN` defined:
  - Adds output `perf_fetched` (32, count of IF/ID loads with valid=1).
  - Adds output `perf_stall_cyc` (32, cycles in FETCH without hit plus cycles in HOLD).
  - Both clear on RST, wrap at 2^32 and freeze in HALTED.
- Not defined: the ports and counters are absent and all other behaviour is identical.

## Test plan

- Reset release, memory always hits, words 0x00A00093 and 0x00100113 at PCs 0 and 4: `instr` shows them in cycles 1 and 2, `instr_pc` is 0 then 4, `instr_valid`=1.
- Memory hit delayed 3 cycles at PC 8: `imem_addr` holds 8 for 3 cycles, `instr_valid` for PC 8 rises one cycle after the hit, no duplicate and no skipped PC.
- `stall` on the same cycle as a hit at PC 0x10, held 2 cycles: state is HOLD, `imem_ren`=0, and after `stall` drops `instr_pc`=0x10, then fetch resumes at 0x14.
- `redirect`=1 with `redirect_pc`=0x203 while `stall`=1 and a skid entry is held: next cycle `imem_addr`=0x200, `instr_valid`=0 and the skid word is never issued.
- `halt` with a valid instruction at PC 0x40: `halted`=1 next cycle, `imem_ren` stays 0 and later `redirect` has no effect; RST returns `pc` to `RESET_PC`.
- With `FETCH_PERF_EN`: 5 hits plus 3 miss cycles give `perf_fetched`=5 and `perf_stall_cyc`=3.
